// File: rtl/risc_pkg.sv
// Shared encodings for the risc sequencer: FSM states, opcodes, ALU selects.
// Pure declarations, no timing or flow control.
package risc_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_BRANCH    = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_NOP0 = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_NOP1 = 4'b1110;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc >= 4'b0010) && (opc <= 4'b1001);
    endfunction

endpackage

// File: rtl/risc_wait_timer.sv
// Counts ready-low cycles of the active memory handshake; flags expiry combinationally
// on the WAIT_MAX-th consecutive low cycle. Clears on any state change.
module risc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expire
);
    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expire = active && !ready && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/risc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: FETCH and MEM stall on their ready input,
// every other state takes one cycle; a stall of WAIT_MAX cycles halts with fault.
module risc_sequencer
    import risc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic              alu_en,
    output logic [2:0]        alu_op,
    input  logic              alu_zero,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired,
    output logic              halted,
    output logic              fault
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              zero_q, zero_d;
    logic              fault_q, fault_d;
    logic              wait_expire;

    logic [3:0]        opc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;
    logic              br_taken;
    logic              retire;

    assign opc      = instr_q[DATA_W-1 -: 4];
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign br_off   = ADDR_W'($signed(instr_q[5:0]));
    assign br_taken = ((opc == OP_BEQ) && zero_q) || ((opc == OP_BNE) && !zero_q);

    risc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != state_q),
        .active ((state_q == S_FETCH) || (state_q == S_MEM)),
        .ready  ((state_q == S_MEM) ? dmem_ready : imem_ready),
        .expire (wait_expire)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        zero_d  = zero_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end else if (wait_expire) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opc)
                    OP_NOP0, OP_NOP1: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = instr_q[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                zero_d = alu_zero;
                if (is_alu_op(opc)) begin
                    state_d = S_WRITEBACK;
                end else if ((opc == OP_LD) || (opc == OP_ST)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (opc == OP_LD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end else if (wait_expire) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_d    = br_taken ? (pc_inc + br_off) : pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Only DECODE/MEM/WRITEBACK/BRANCH can enter FETCH, so any entry into FETCH or HALT retires.
        retire    = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_HALT));
        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            zero_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            zero_q    <= zero_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        alu_op = 3'b000;
        if (state_q == S_EXECUTE) begin
            if (is_alu_op(opc)) begin
                alu_op = 3'(opc - 4'd2);
            end else if ((opc == OP_LD) || (opc == OP_ST)) begin
                alu_op = ALU_ADD;
            end else begin
                alu_op = ALU_SUB;
            end
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign alu_en    = (state_q == S_EXECUTE);
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) && (opc == OP_ST);
    assign rf_we     = (state_q == S_WRITEBACK);
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign retired   = retired_q;
    assign halted    = (state_q == S_HALT);
    assign fault     = fault_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer: ALU/LD/ST/branch/jump/wrap, wait timeout and reset cases.
module tb_risc_sequencer;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    risc_sequencer #(.DATA_W(16), .ADDR_W(8), .CNT_W(16), .WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .instr      (instr),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .alu_zero   (alu_zero),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .pc         (pc),
        .state      (state),
        .retired    (retired),
        .halted     (halted),
        .fault      (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to a FETCH cycle, leaving the sequencer in DECODE.
    task automatic fetch(input logic [15:0] data);
        imem_data  = data;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
    endtask

    // Fetch a one-cycle branch instruction, drive alu_zero in EXECUTE, return to FETCH.
    task automatic branch(input logic [15:0] data, input logic zero);
        fetch(data);
        step();
        chk("br_alu_op", 32'(alu_op), 32'(ALU_SUB));
        alu_zero = zero;
        step();
        alu_zero = ~zero;
        step();
        alu_zero = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
        alu_zero   = 1'b0;
        dmem_ready = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'(S_FETCH));
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_strobes", {27'b0, imem_req, alu_en, dmem_req, dmem_we, rf_we}, 32'b10000);
        chk("rst_flags", {30'b0, halted, fault}, 32'h0);
        reset = 1'b0;

        // ALU opcode 0011 at pc 0: EXECUTE in cycle 3, WRITEBACK in cycle 4.
        fetch(16'h3000);
        chk("alu_decode", 32'(state), 32'(S_DECODE));
        chk("alu_instr", 32'(instr), 32'h3000);
        step();
        chk("alu_en", {31'b0, alu_en}, 32'h1);
        chk("alu_op", 32'(alu_op), 32'h1);
        step();
        chk("alu_rf_we", {31'b0, rf_we}, 32'h1);
        step();
        chk("alu_pc", 32'(pc), 32'h1);
        chk("alu_retired", 32'(retired), 32'h1);

        // LD with three stalled MEM cycles: dmem_req for 4 cycles, then writeback.
        fetch(16'h0000);
        step();
        chk("ld_alu_op", 32'(alu_op), 32'h0);
        step();
        begin
            int n = 0;
            int we_seen = 0;
            while (dmem_req && n < 20) begin
                n++;
                if (dmem_we) we_seen++;
                dmem_ready = (n == 4);
                step();
            end
            dmem_ready = 1'b0;
            chk("ld_req_cycles", 32'(n), 32'd4);
            chk("ld_we_cycles", 32'(we_seen), 32'd0);
        end
        chk("ld_rf_we", {31'b0, rf_we}, 32'h1);
        step();
        chk("ld_rf_we_one", {31'b0, rf_we}, 32'h0);
        chk("ld_pc", 32'(pc), 32'h2);
        chk("ld_retired", 32'(retired), 32'h2);

        // BEQ at pc 2, offset -2: taken -> 1.
        branch(16'hB03E, 1'b1);
        chk("beq_taken_pc", 32'(pc), 32'h1);
        chk("beq_taken_ret", 32'(retired), 32'h3);
        fetch(16'hA000);
        step();
        chk("nop_pc", 32'(pc), 32'h2);
        // Same BEQ not taken -> 3.
        branch(16'hB03E, 1'b0);
        chk("beq_nt_pc", 32'(pc), 32'h3);
        // BNE with zero clear is taken: 3+1-2 = 2.
        branch(16'hC03E, 1'b0);
        chk("bne_taken_pc", 32'(pc), 32'h2);
        chk("bne_retired", 32'(retired), 32'h6);

        // JMP to 0xFF, NOP wraps to 0x00, JMP to 0x5A.
        fetch(16'hD0FF);
        step();
        chk("jmp_ff_pc", 32'(pc), 32'hFF);
        fetch(16'hE000);
        step();
        chk("wrap_pc", 32'(pc), 32'h00);
        fetch(16'hD05A);
        step();
        chk("jmp_5a_pc", 32'(pc), 32'h5A);
        chk("jmp_retired", 32'(retired), 32'h9);

        // ST completing in first MEM cycle: write qualifier set, no writeback.
        fetch(16'h1000);
        step();
        step();
        chk("st_we", {30'b0, dmem_req, dmem_we}, 32'b11);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        chk("st_state", 32'(state), 32'(S_FETCH));
        chk("st_pc", 32'(pc), 32'h5B);
        chk("st_retired", 32'(retired), 32'hA);

        // Fetch ready on the 15th waiting cycle still completes.
        for (int i = 0; i < 14; i++) step();
        chk("late_still_fetch", 32'(state), 32'(S_FETCH));
        fetch(16'hA000);
        chk("late_decode", 32'(state), 32'(S_DECODE));
        chk("late_no_fault", {31'b0, fault}, 32'h0);
        step();
        chk("late_pc", 32'(pc), 32'h5C);

        // Fetch never ready: HALT with fault after 15 cycles.
        for (int i = 0; i < 14; i++) step();
        chk("to_pre_state", 32'(state), 32'(S_FETCH));
        step();
        chk("to_state", 32'(state), 32'(S_HALT));
        chk("to_flags", {30'b0, halted, fault}, 32'b11);
        chk("to_strobes", {27'b0, imem_req, alu_en, dmem_req, dmem_we, rf_we}, 32'h0);
        chk("to_retired", 32'(retired), 32'hC);
        imem_ready = 1'b1;
        imem_data  = 16'hA000;
        step();
        step();
        imem_ready = 1'b0;
        chk("halt_frozen_pc", 32'(pc), 32'h5C);
        chk("halt_frozen_ret", 32'(retired), 32'hC);
        chk("halt_hold", 32'(state), 32'(S_HALT));

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_state", 32'(state), 32'(S_FETCH));
        chk("rst2_pc_ret", {8'b0, pc, retired}, 32'h0);
        chk("rst2_flags", {29'b0, imem_req, halted, fault}, 32'b100);

        // HLT instruction: clean halt, no fault, retires once.
        fetch(16'hF000);
        step();
        chk("hlt_state", 32'(state), 32'(S_HALT));
        chk("hlt_flags", {30'b0, halted, fault}, 32'b10);
        chk("hlt_retired", 32'(retired), 32'h1);

        // Reset in the middle of a stalled MEM access.
        reset = 1'b1;
        step();
        reset = 1'b0;
        fetch(16'h0000);
        step();
        step();
        step();
        chk("mid_mem_req", {31'b0, dmem_req}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_req", {31'b0, dmem_req}, 32'h0);
        chk("mid_rst_state", 32'(state), 32'(S_FETCH));
        chk("mid_rst_pc_ret", {8'b0, pc, retired}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_sequencer.md
RISC_SEQUENCER -- requirements
Module: risc_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: instruction/data width; SHALL be >= 12.
REQ-002 Parameter ADDR_W, default 8: PC/instruction-address width; SHALL satisfy 6 <= ADDR_W <= DATA_W-4.
REQ-003 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 Parameter WAIT_MAX, default 15: maximum memory wait cycles before fault.
REQ-005 Port list (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge.
  reset  in  1  synchronous, active-high.
  imem_req  out  1  instruction fetch request.
  imem_addr  out  ADDR_W  fetch address (current PC).
  imem_ready  in  1  fetch data valid this cycle.
  imem_data  in  DATA_W  fetched instruction.
  instr  out  DATA_W  latched current instruction.
  alu_en  out  1  datapath ALU strobe.
  alu_op  out  3  ALU operation select.
  alu_zero  in  1  ALU zero flag, valid in the cycle alu_en is high.
  dmem_req  out  1  data memory request.
  dmem_we  out  1  write qualifier for dmem_req.
  dmem_ready  in  1  data access complete this cycle.
  rf_we  out  1  register-file write strobe.
  pc  out  ADDR_W  program counter.
  state  out  3  current FSM state encoding.
  retired  out  CNT_W  retired-instruction count.
  halted  out  1  HALT reached.
  fault  out  1  memory timeout occurred.

Function
REQ-006 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, BRANCH, HALT.
REQ-007 Opcode = instr[DATA_W-1 -: 4]; 0000 LD, 0001 ST, 0010-1001 ALU (alu_op = opcode-2), 1010/1110 NOP, 1011 BEQ, 1100 BNE, 1101 JMP, 1111 HLT.
REQ-008 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 the sequencer latches imem_data into instr and moves to DECODE next cycle; otherwise it holds.
REQ-009 DECODE (1 cycle): NOP -> pc+1, FETCH; JMP -> pc=instr[ADDR_W-1:0], FETCH; HLT -> HALT; all others -> EXECUTE.
REQ-010 EXECUTE (1 cycle, alu_en=1): alu_op=opcode-2 for ALU, 000 for LD/ST, 001 for BEQ/BNE; next ALU->WRITEBACK, LD/ST->MEM, BEQ/BNE->BRANCH; alu_zero is registered in this cycle.
REQ-011 MEM: dmem_req=1, dmem_we=1 only for ST; on dmem_ready: LD->WRITEBACK, ST->pc+1, FETCH.
REQ-012 WRITEBACK (1 cycle): rf_we=1; pc+1; FETCH.
REQ-013 BRANCH (1 cycle): taken when (BEQ and zero) or (BNE and not zero); taken pc = pc+1+sign_extend(instr[5:0]) modulo 2^ADDR_W, else pc+1; FETCH.
REQ-014 All PC arithmetic SHALL wrap modulo 2^ADDR_W (pc=2^ADDR_W-1 plus 1 -> 0).
REQ-015 A retire (retired+1, wrapping) SHALL occur exactly on every transition into FETCH from DECODE, MEM, WRITEBACK or BRANCH, and on entry to HALT.
REQ-016 The wait counter SHALL clear on entry to FETCH/MEM and increment each cycle the ready input is low; when it reaches WAIT_MAX with ready still low, the FSM SHALL go to HALT and set fault=1; ready on the WAIT_MAX-th cycle SHALL complete normally.
REQ-017 HALT: all strobes 0, halted=1, pc/retired frozen until reset.
REQ-018 Strobes (imem_req, alu_en, dmem_req, dmem_we, rf_we) SHALL be Moore outputs of the state, never asserted outside their listed states.
REQ-019 imem_ready and dmem_ready SHALL be ignored outside FETCH and MEM respectively.

Reset
REQ-020 reset=1 at a clock edge SHALL, in any state (including mid-wait), force FETCH, pc=0, instr=0, retired=0, wait counter=0, halted=0, fault=0, latched zero=0.
REQ-021 During and directly after reset all strobes SHALL be 0 except imem_req, which is 1 in the first post-reset cycle (FETCH).

Structure
REQ-022 State encodings, opcode constants and the alu_op values for add/sub SHALL reside in a shared package risc_pkg.
REQ-023 The wait counter with timeout compare SHALL be the sub-module risc_wait_timer; the FSM, PC and counters SHALL stay in risc_sequencer.

Verification
REQ-024 Reset, then ALU opcode 0011 fetched with imem_ready=1 -> alu_en with alu_op=001 in cycle 3, rf_we in cycle 4, pc=1, retired=1.
REQ-025 LD with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then rf_we for 1 cycle; total 7 cycles.
REQ-026 BEQ at pc=0x02, offset 6'b111110, alu_zero=1 -> pc=0x01; same with alu_zero=0 -> pc=0x03.
REQ-027 ADDR_W=8, pc=0xFF, NOP -> pc=0x00; JMP instr low byte 0x5A -> pc=0x5A.
REQ-028 imem_ready held low -> after WAIT_MAX cycles state=HALT, fault=1, halted=1; reset -> clean FETCH at pc=0.
REQ-029 Reset asserted mid-MEM with dmem_req high -> next cycle dmem_req=0, state=FETCH, pc=0, retired=0.
